phase_frame_ctrl: RTL and testbench

PHASE_FRAME_CTRL -- requirements
Module: phase_frame_ctrl

---
 rtl/phase_frame_ctrl.sv | 244 ++++++++++++++++++++++++
 tb/tb_phase_frame_ctrl.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_frame_ctrl.sv
// phase_frame_ctrl: byte-framed phase update controller; staged payloads land in
// a shadow bank that is swapped into the active phases on a PWM period tick.
module phase_frame_ctrl #(
    parameter int NUM_CHANNELS = 4,
    parameter int TIMEOUT_CYC  = 1_000_000
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst,
    input  logic                      rxfifo_empty,
    output logic                      rxfifo_rd,
    input  logic                      rxfifo_valid,
    input  logic [7:0]                rxfifo_data,
    input  logic                      txfifo_full,
    output logic                      txfifo_wr,
    output logic [7:0]                txfifo_data,
    input  logic                      period_tick,
    output logic [NUM_CHANNELS*8-1:0] phases_flat,
    output logic                      commit_pending,
    output logic                      busy,
    output logic [7:0]                err_cnt
);

    localparam int IW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int CW = $clog2(NUM_CHANNELS + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [7:0] B_SOF = 8'hAA;
    localparam logic [7:0] B_EOF = 8'h55;
    localparam logic [7:0] B_ACK = 8'h06;
    localparam logic [7:0] B_NAK = 8'h15;
    localparam logic [7:0] NCH   = 8'(NUM_CHANNELS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CODE,
        S_ARG,
        S_PAYLOAD,
        S_SUFFIX,
        S_APPLY,
        S_ACK
    } state_t;

    state_t r_state;
    state_t w_next;

    logic w_consume;
    logic w_in_frame;
    logic w_byte;
    logic w_fetch;
    logic w_code_ok;
    logic w_arg_ok;
    logic w_nak;
    logic w_timeout;

    logic                      r_rd;
    logic                      r_rd_out;
    logic [TW-1:0]             r_to;
    logic [1:0]                r_code;
    logic [IW-1:0]             r_chan;
    logic [CW-1:0]             r_cnt;
    logic [CW-1:0]             r_idx;
    logic [7:0]                r_stage  [NUM_CHANNELS];
    logic [7:0]                r_shadow [NUM_CHANNELS];
    logic [NUM_CHANNELS*8-1:0] r_phases;
    logic                      r_commit;
    logic [7:0]                r_resp;
    logic [7:0]                r_err;

    // A byte is accepted in any consuming state, even with no read
    // outstanding, so a response to a read issued before reset is not lost.
    assign w_byte  = rxfifo_valid & w_consume;
    assign w_fetch = w_consume & ~r_rd_out & ~rxfifo_empty;

    assign w_timeout = w_in_frame & ~rxfifo_valid
                     & (r_to == TW'(TIMEOUT_CYC - 1));

    assign w_code_ok = (rxfifo_data == 8'h01)
                     | (rxfifo_data == 8'h02)
                     | (rxfifo_data == 8'h03);

    always_comb begin
        w_arg_ok = 1'b0;
        unique case (r_code)
            2'd1:    w_arg_ok = (rxfifo_data < NCH);
            2'd2:    w_arg_ok = (rxfifo_data != 8'h00) && (rxfifo_data <= NCH);
            2'd3:    w_arg_ok = 1'b1;
            default: w_arg_ok = 1'b0;
        endcase
    end

    assign w_nak = w_byte & (((r_state == S_CODE)   & ~w_code_ok)
                           | ((r_state == S_ARG)    & ~w_arg_ok)
                           | ((r_state == S_SUFFIX) & (rxfifo_data != B_EOF)));

    // FSM: state register
    always_ff @(posedge sys_clk) begin
        if (sys_rst) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // FSM: next state
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_byte && rxfifo_data == B_SOF) w_next = S_CODE;
            end
            S_CODE: begin
                if (w_timeout)   w_next = S_IDLE;
                else if (w_byte) w_next = w_code_ok ? S_ARG : S_ACK;
            end
            S_ARG: begin
                if (w_timeout)          w_next = S_IDLE;
                else if (w_byte) begin
                    if (!w_arg_ok)      w_next = S_ACK;
                    else if (r_code == 2'd3) w_next = S_SUFFIX;
                    else                w_next = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (w_timeout) w_next = S_IDLE;
                else if (w_byte && r_idx == r_cnt - CW'(1)) w_next = S_SUFFIX;
            end
            S_SUFFIX: begin
                if (w_timeout)   w_next = S_IDLE;
                else if (w_byte) w_next = (rxfifo_data == B_EOF) ? S_APPLY : S_ACK;
            end
            S_APPLY: w_next = S_ACK;
            S_ACK: begin
                if (!txfifo_full) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        w_consume  = 1'b0;
        w_in_frame = 1'b0;
        txfifo_wr  = 1'b0;
        busy       = 1'b1;
        unique case (r_state)
            S_IDLE: begin
                w_consume = 1'b1;
                busy      = 1'b0;
            end
            S_CODE, S_ARG, S_PAYLOAD, S_SUFFIX: begin
                w_consume  = 1'b1;
                w_in_frame = 1'b1;
            end
            S_ACK:   txfifo_wr = ~txfifo_full;
            default: ;
        endcase
    end

    // Read request and inter-byte timeout
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_rd     <= 1'b0;
            r_rd_out <= 1'b0;
            r_to     <= '0;
        end else begin
            r_rd     <= w_fetch;
            r_rd_out <= w_fetch | (r_rd_out & ~rxfifo_valid);
            if (!w_in_frame || rxfifo_valid || w_timeout) r_to <= '0;
            else                                          r_to <= r_to + TW'(1);
        end
    end

    // Frame header capture and payload staging
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_code <= '0;
            r_chan <= '0;
            r_cnt  <= '0;
            r_idx  <= '0;
            for (int i = 0; i < NUM_CHANNELS; i++) r_stage[i] <= '0;
        end else if (w_byte) begin
            unique case (r_state)
                S_CODE: r_code <= rxfifo_data[1:0];
                S_ARG: begin
                    r_chan <= rxfifo_data[IW-1:0];
                    r_cnt  <= (r_code == 2'd1) ? CW'(1) : rxfifo_data[CW-1:0];
                    r_idx  <= '0;
                end
                S_PAYLOAD: begin
                    r_stage[r_idx[IW-1:0]] <= rxfifo_data;
                    r_idx <= r_idx + CW'(1);
                end
                S_SUFFIX: begin
                    if (rxfifo_data != B_EOF)
                        for (int i = 0; i < NUM_CHANNELS; i++) r_stage[i] <= '0;
                end
                default: ;
            endcase
        end
    end

    // Shadow bank, commit flag and active phases; a tick samples the
    // pre-APPLY shadow and pending values of the same cycle.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_commit <= 1'b0;
            r_phases <= '0;
            for (int i = 0; i < NUM_CHANNELS; i++) r_shadow[i] <= '0;
        end else begin
            if (period_tick && r_commit) begin
                r_commit <= 1'b0;
                for (int i = 0; i < NUM_CHANNELS; i++)
                    r_phases[8*i +: 8] <= r_shadow[i];
            end
            if (r_state == S_APPLY) begin
                unique case (r_code)
                    2'd1: r_shadow[r_chan] <= r_stage[0];
                    2'd2: begin
                        for (int i = 0; i < NUM_CHANNELS; i++)
                            if (i < int'(r_cnt)) r_shadow[i] <= r_stage[i];
                    end
                    2'd3:    r_commit <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // Response byte and saturating error counter
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_resp <= '0;
            r_err  <= '0;
        end else begin
            if (w_nak)                     r_resp <= B_NAK;
            else if (r_state == S_APPLY)   r_resp <= B_ACK;
            if ((w_nak || w_timeout) && r_err != 8'hFF) r_err <= r_err + 8'd1;
        end
    end

    assign rxfifo_rd      = r_rd;
    assign txfifo_data    = r_resp;
    assign phases_flat    = r_phases;
    assign commit_pending = r_commit;
    assign err_cnt        = r_err;

endmodule

// File: tb/tb_phase_frame_ctrl.sv
// Bench for phase_frame_ctrl: directed frames plus randomized frames checked
// against a frame-level reference model of the protocol.
module tb_phase_frame_ctrl;

    localparam int NC = 4;
    localparam int TO = 100;

    logic            sys_clk;
    logic            sys_rst;
    logic            rxfifo_empty;
    logic            rxfifo_rd;
    logic            rxfifo_valid;
    logic [7:0]      rxfifo_data;
    logic            txfifo_full;
    logic            txfifo_wr;
    logic [7:0]      txfifo_data;
    logic            period_tick;
    logic [NC*8-1:0] phases_flat;
    logic            commit_pending;
    logic            busy;
    logic [7:0]      err_cnt;

    phase_frame_ctrl #(.NUM_CHANNELS(NC), .TIMEOUT_CYC(TO)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .rxfifo_empty(rxfifo_empty), .rxfifo_rd(rxfifo_rd),
        .rxfifo_valid(rxfifo_valid), .rxfifo_data(rxfifo_data),
        .txfifo_full(txfifo_full), .txfifo_wr(txfifo_wr),
        .txfifo_data(txfifo_data), .period_tick(period_tick),
        .phases_flat(phases_flat), .commit_pending(commit_pending),
        .busy(busy), .err_cnt(err_cnt)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];
    int rd_cnt, wr_cnt, wr_full_cnt, rd_at_wr;
    int n_pass, n_total;

    logic [7:0] m_shadow [NC];
    logic [7:0] m_phase  [NC];
    bit         m_pending;
    int         m_err;

    // Receive FIFO: answers each read one cycle later
    always @(posedge sys_clk) begin
        rxfifo_valid <= 1'b0;
        if (rxfifo_rd === 1'b1 && rx_q.size() > 0) begin
            rxfifo_valid <= 1'b1;
            rxfifo_data  <= rx_q.pop_front();
        end
        rxfifo_empty <= (rx_q.size() == 0);
    end

    always @(negedge sys_clk) begin
        if (rxfifo_rd === 1'b1) rd_cnt++;
        if (txfifo_wr === 1'b1) begin
            tx_q.push_back(txfifo_data);
            wr_cnt++;
            rd_at_wr = rd_cnt;
            if (txfifo_full) wr_full_cnt++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < NC; i++) begin
            m_shadow[i] = 8'h00;
            m_phase[i]  = 8'h00;
        end
        m_pending = 0;
        m_err     = 0;
    endtask

    function automatic logic [NC*8-1:0] exp_phases();
        logic [NC*8-1:0] v;
        for (int i = 0; i < NC; i++) v[8*i +: 8] = m_phase[i];
        return v;
    endfunction

    // Frame-level model: bytes are v's low n bytes, first byte most significant
    task automatic model_frame(input logic [127:0] v, input int n, output int resp);
        logic [7:0] b [16];
        logic [7:0] stg [NC];
        int p, code, arg, len;
        for (int i = 0; i < n; i++) b[i] = v[8*(n-1-i) +: 8];
        resp = -1;
        p = 0;
        while (p < n && b[p] != 8'hAA) p++;
        if (p + 2 >= n + 1) return;
        code = int'(b[p+1]);
        if (code < 1 || code > 3) begin
            resp = 'h15;
            if (m_err < 255) m_err++;
            return;
        end
        arg = int'(b[p+2]);
        if ((code == 1 && arg >= NC) || (code == 2 && (arg == 0 || arg > NC))) begin
            resp = 'h15;
            if (m_err < 255) m_err++;
            return;
        end
        len = (code == 1) ? 1 : (code == 2) ? arg : 0;
        for (int k = 0; k < len; k++) stg[k] = b[p+3+k];
        if (b[p+3+len] != 8'h55) begin
            resp = 'h15;
            if (m_err < 255) m_err++;
            return;
        end
        resp = 'h06;
        if (code == 1) m_shadow[arg] = stg[0];
        else if (code == 2) for (int k = 0; k < len; k++) m_shadow[k] = stg[k];
        else m_pending = 1;
    endtask

    task automatic send(input logic [127:0] v, input int n,
                        output int resp, output int reads);
        int rd0;
        tx_q.delete();
        rd0 = rd_cnt;
        for (int i = n - 1; i >= 0; i--) rx_q.push_back(v[8*i +: 8]);
        resp  = -1;
        reads = -1;
        for (int i = 0; i < 400 && tx_q.size() == 0; i++) cyc(1);
        if (tx_q.size() > 0) begin
            resp  = int'(tx_q.pop_front());
            reads = rd_at_wr - rd0;
        end
        for (int i = 0; i < 100 && (rx_q.size() != 0 || busy); i++) cyc(1);
        cyc(4);
    endtask

    task automatic tick();
        period_tick = 1'b1;
        cyc(1);
        period_tick = 1'b0;
        if (m_pending) begin
            for (int i = 0; i < NC; i++) m_phase[i] = m_shadow[i];
            m_pending = 0;
        end
        cyc(1);
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        cyc(3);
        n_total++;
        if (phases_flat !== '0 || commit_pending !== 1'b0 || busy !== 1'b0)
            $display("FAIL reset_state: phases %h pend %b busy %b want 0 0 0",
                     phases_flat, commit_pending, busy);
        else n_pass++;
        n_total++;
        if (err_cnt !== 8'd0 || rxfifo_rd !== 1'b0 || txfifo_wr !== 1'b0 || txfifo_data !== 8'd0)
            $display("FAIL reset_io: err %h rd %b wr %b data %h want 0 0 0 0",
                     err_cnt, rxfifo_rd, txfifo_wr, txfifo_data);
        else n_pass++;
        sys_rst = 1'b0;
        m_reset();
        cyc(2);
    endtask

    task automatic test_set_one();
        int r, e, rd;
        model_frame(128'hAA01027F55, 5, e);
        send(128'hAA01027F55, 5, r, rd);
        n_total++;
        if (r !== e || r !== 'h06) $display("FAIL set_one_ack: got %h want %h", r, e);
        else n_pass++;
        n_total++;
        if (phases_flat !== exp_phases())
            $display("FAIL set_one_no_swap: got %h want %h", phases_flat, exp_phases());
        else n_pass++;
        model_frame(128'hAA030055, 4, e);
        send(128'hAA030055, 4, r, rd);
        n_total++;
        if (r !== e || commit_pending !== 1'b1)
            $display("FAIL commit_ack: resp %h pend %b want %h 1", r, commit_pending, e);
        else n_pass++;
        tick();
        n_total++;
        if (phases_flat !== exp_phases() || phases_flat[23:16] !== 8'h7F || commit_pending !== 1'b0)
            $display("FAIL set_one_swap: got %h pend %b want %h 0",
                     phases_flat, commit_pending, exp_phases());
        else n_pass++;
    endtask

    task automatic test_set_range();
        int r, e, rd;
        model_frame(128'hAA020410203040_55, 8, e);
        send(128'hAA020410203040_55, 8, r, rd);
        n_total++;
        if (r !== e) $display("FAIL range_ack: got %h want %h", r, e);
        else n_pass++;
        model_frame(128'hAA030055, 4, e);
        send(128'hAA030055, 4, r, rd);
        tick();
        n_total++;
        if (phases_flat !== 32'h40302010 || phases_flat !== exp_phases())
            $display("FAIL range_swap: got %h want %h", phases_flat, 32'h40302010);
        else n_pass++;
    endtask

    task automatic test_nak();
        int r, e, rd;
        model_frame(128'hAA01053355, 5, e);
        send(128'hAA01053355, 5, r, rd);
        n_total++;
        if (r !== e || r !== 'h15) $display("FAIL bad_chan_nak: got %h want %h", r, e);
        else n_pass++;
        n_total++;
        if (rd !== 3) $display("FAIL bad_chan_reads: got %0d want 3", rd);
        else n_pass++;
        n_total++;
        if (err_cnt !== 8'(m_err) || m_err != 1)
            $display("FAIL bad_chan_err: got %0d want %0d", err_cnt, m_err);
        else n_pass++;
        model_frame(128'hAA02011154, 5, e);
        send(128'hAA02011154, 5, r, rd);
        n_total++;
        if (r !== e || err_cnt !== 8'(m_err))
            $display("FAIL bad_suffix: resp %h err %0d want %h %0d", r, err_cnt, e, m_err);
        else n_pass++;
        model_frame(128'hAA030055, 4, e);
        send(128'hAA030055, 4, r, rd);
        tick();
        n_total++;
        if (phases_flat !== exp_phases())
            $display("FAIL nak_shadow: got %h want %h", phases_flat, exp_phases());
        else n_pass++;
    endtask

    task automatic test_tick_collision();
        int r, e, rd;
        bit hit;
        model_frame(128'hAA0100A555, 5, e);
        send(128'hAA0100A555, 5, r, rd);
        tx_q.delete();
        rx_q.push_back(8'hAA);
        rx_q.push_back(8'h03);
        rx_q.push_back(8'h00);
        rx_q.push_back(8'h55);
        hit = 0;
        for (int i = 0; i < 100 && !hit; i++) begin
            cyc(1);
            if (rxfifo_valid === 1'b1 && rxfifo_data === 8'h55) hit = 1;
        end
        n_total++;
        if (!hit) $display("FAIL collide_suffix: got %b want 1", hit);
        else n_pass++;
        tick();
        model_frame(128'hAA030055, 4, e);
        for (int i = 0; i < 50 && tx_q.size() == 0; i++) cyc(1);
        r = (tx_q.size() > 0) ? int'(tx_q.pop_front()) : -1;
        n_total++;
        if (r !== e || phases_flat !== exp_phases() || commit_pending !== 1'b1)
            $display("FAIL collide_no_swap: resp %h phases %h pend %b want %h %h 1",
                     r, phases_flat, commit_pending, e, exp_phases());
        else n_pass++;
        cyc(3);
        tick();
        n_total++;
        if (phases_flat !== exp_phases() || phases_flat[7:0] !== 8'hA5)
            $display("FAIL collide_next_swap: got %h want %h", phases_flat, exp_phases());
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int e, w0;
        txfifo_full = 1'b1;
        tx_q.delete();
        w0 = wr_cnt;
        model_frame(128'hAA0103C355, 5, e);
        rx_q.push_back(8'hAA);
        rx_q.push_back(8'h01);
        rx_q.push_back(8'h03);
        rx_q.push_back(8'hC3);
        rx_q.push_back(8'h55);
        cyc(40);
        n_total++;
        if (wr_cnt != w0 || busy !== 1'b1 || txfifo_data !== 8'(e))
            $display("FAIL full_hold: writes %0d busy %b data %h want 0 1 %h",
                     wr_cnt - w0, busy, txfifo_data, 8'(e));
        else n_pass++;
        txfifo_full = 1'b0;
        cyc(10);
        n_total++;
        if (wr_cnt - w0 != 1 || wr_full_cnt != 0 || busy !== 1'b0)
            $display("FAIL full_release: writes %0d bad %0d busy %b want 1 0 0",
                     wr_cnt - w0, wr_full_cnt, busy);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int w0;
        w0 = wr_cnt;
        rx_q.push_back(8'hAA);
        rx_q.push_back(8'h02);
        cyc(50);
        n_total++;
        if (busy !== 1'b1) $display("FAIL timeout_early: busy %b want 1", busy);
        else n_pass++;
        cyc(100);
        if (m_err < 255) m_err++;
        n_total++;
        if (busy !== 1'b0 || wr_cnt != w0 || err_cnt !== 8'(m_err))
            $display("FAIL timeout_abort: busy %b writes %0d err %0d want 0 0 %0d",
                     busy, wr_cnt - w0, err_cnt, m_err);
        else n_pass++;
    endtask

    task automatic test_reset_midframe();
        int r, e, rd;
        rx_q.push_back(8'hAA);
        rx_q.push_back(8'h02);
        rx_q.push_back(8'h04);
        rx_q.push_back(8'h10);
        rx_q.push_back(8'h20);
        cyc(8);
        sys_rst = 1'b1;
        rx_q.delete();
        cyc(2);
        sys_rst = 1'b0;
        m_reset();
        cyc(6);
        n_total++;
        if (busy !== 1'b0 || phases_flat !== '0 || err_cnt !== 8'd0 || commit_pending !== 1'b0)
            $display("FAIL mid_reset: busy %b phases %h err %0d pend %b want 0 0 0 0",
                     busy, phases_flat, err_cnt, commit_pending);
        else n_pass++;
        model_frame(128'hAA01015A55, 5, e);
        send(128'hAA01015A55, 5, r, rd);
        model_frame(128'hAA030055, 4, e);
        send(128'hAA030055, 4, r, rd);
        tick();
        n_total++;
        if (r !== e || phases_flat !== exp_phases())
            $display("FAIL after_reset: resp %h phases %h want %h %h",
                     r, phases_flat, e, exp_phases());
        else n_pass++;
    endtask

    task automatic test_random();
        logic [127:0] v;
        logic [7:0]   x;
        int n, r, e, rd, kind, len;
        for (int it = 0; it < 40; it++) begin
            v = '0;
            n = 0;
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                x = 8'($urandom_range(0, 255));
                if (x == 8'hAA) x = 8'h00;
                v = {v[119:0], x}; n++;
            end
            v = {v[119:0], 8'hAA}; n++;
            kind = $urandom_range(0, 5);
            case (kind)
                0, 5: begin
                    v = {v[119:0], 8'h01}; n++;
                    v = {v[119:0], 8'($urandom_range(0, NC - 1))}; n++;
                    v = {v[119:0], 8'($urandom_range(0, 255))}; n++;
                    x = (kind == 5) ? 8'($urandom_range(0, 255)) : 8'h55;
                    if (kind == 5 && x == 8'h55) x = 8'h54;
                    v = {v[119:0], x}; n++;
                end
                1: begin
                    len = $urandom_range(1, NC);
                    v = {v[119:0], 8'h02}; n++;
                    v = {v[119:0], 8'(len)}; n++;
                    for (int k = 0; k < len; k++) begin
                        v = {v[119:0], 8'($urandom_range(0, 255))}; n++;
                    end
                    v = {v[119:0], 8'h55}; n++;
                end
                2: begin
                    v = {v[119:0], 8'h03}; n++;
                    v = {v[119:0], 8'($urandom_range(0, 255))}; n++;
                    v = {v[119:0], 8'h55}; n++;
                end
                3: begin
                    x = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(4, 255));
                    v = {v[119:0], x}; n++;
                end
                default: begin
                    if ($urandom_range(0, 1) == 0) begin
                        v = {v[119:0], 8'h01}; n++;
                        x = 8'($urandom_range(NC, 255));
                    end else begin
                        v = {v[119:0], 8'h02}; n++;
                        x = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(NC + 1, 255));
                    end
                    v = {v[119:0], x}; n++;
                end
            endcase
            model_frame(v, n, e);
            send(v, n, r, rd);
            n_total++;
            if (r !== e || err_cnt !== 8'(m_err))
                $display("FAIL rand_frame%0d: resp %h err %0d want %h %0d",
                         it, r, err_cnt, e, m_err);
            else n_pass++;
            if (it % 5 == 4) begin
                model_frame(128'hAA030055, 4, e);
                send(128'hAA030055, 4, r, rd);
                tick();
                n_total++;
                if (phases_flat !== exp_phases() || commit_pending !== 1'b0)
                    $display("FAIL rand_swap%0d: got %h pend %b want %h 0",
                             it, phases_flat, commit_pending, exp_phases());
                else n_pass++;
            end
        end
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        rd_cnt = 0; wr_cnt = 0; wr_full_cnt = 0; rd_at_wr = 0;
        sys_rst = 1'b1;
        txfifo_full = 1'b0;
        period_tick = 1'b0;
        m_reset();
        test_reset();
        test_set_one();
        test_set_range();
        test_nak();
        test_tick_collision();
        test_backpressure();
        test_timeout();
        test_reset_midframe();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
